// File: rtl/uart_pkt_pkg.sv
// Shared types and default constants for the UART packet scheduler.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GUARD,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_t;

  localparam logic [7:0] HDR_A_DEF = 8'hA5;
  localparam logic [7:0] HDR_B_DEF = 8'h5A;

endpackage

// File: rtl/uart_pkt_sched_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not served last wins.
module rr_arb2
  import uart_pkt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  req_id_t last_q;

  // NOTE: every output gets a default before any branch, so no path infers a latch.
  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (en_i) begin
      if (req_a_i && (!req_b_i || last_q == REQ_B)) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_B;
    end else if (gnt_a_o) begin
      last_q <= REQ_A;
    end else if (gnt_b_o) begin
      last_q <= REQ_B;
    end
  end

endmodule

// File: rtl/uart_pkt_sched.sv
// Shares one uart_tx between two requesters: frames header, payload, checksum,
// one trmt per byte, waiting on tx_done between bytes.
module uart_pkt_sched
  import uart_pkt_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] HDR_A         = HDR_A_DEF,
  parameter logic [7:0] HDR_B         = HDR_B_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_a,
  input  logic [8*PAYLOAD_BYTES-1:0] payload_a,
  input  logic                       req_b,
  input  logic [8*PAYLOAD_BYTES-1:0] payload_b,
  output logic                       gnt_a,
  output logic                       gnt_b,
  output logic                       done_a,
  output logic                       done_b,
  output logic                       busy,
  output logic                       trmt,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done
);

  localparam int                PL_W     = 8 * PAYLOAD_BYTES;
  localparam int                IDX_W    = $clog2(PAYLOAD_BYTES + 3);
  localparam logic [IDX_W-1:0]  CSUM_IDX = IDX_W'(PAYLOAD_BYTES + 1);

  state_t           state_q;
  req_id_t          srv_q;
  logic [IDX_W-1:0] idx_q;
  logic [PL_W-1:0]  shreg_q;
  logic [7:0]       csum_q;
  logic [7:0]       tx_data_q;
  logic             gnt_a_q, gnt_b_q, done_a_q, done_b_q, busy_q, trmt_q;

  logic       arb_gnt_a, arb_gnt_b;
  logic [7:0] cur_byte_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == IDLE),
    .req_a_i (req_a),
    .req_b_i (req_b),
    .gnt_a_o (arb_gnt_a),
    .gnt_b_o (arb_gnt_b)
  );

  // Byte index 0 is the header, 1..PAYLOAD_BYTES the payload, then the checksum.
  always_comb begin
    cur_byte_d = shreg_q[7:0];
    if (idx_q == '0) begin
      cur_byte_d = (srv_q == REQ_A) ? HDR_A : HDR_B;
    end else if (idx_q == CSUM_IDX) begin
      cur_byte_d = ~csum_q;
    end
  end

  // NOTE: datapath registers are reset as well, since tx_data must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      srv_q     <= REQ_A;
      idx_q     <= '0;
      shreg_q   <= '0;
      csum_q    <= '0;
      tx_data_q <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      trmt_q    <= 1'b0;
    end else begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      trmt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_gnt_a || arb_gnt_b) begin
            gnt_a_q <= arb_gnt_a;
            gnt_b_q <= arb_gnt_b;
            srv_q   <= arb_gnt_b ? REQ_B : REQ_A;
            shreg_q <= arb_gnt_b ? payload_b : payload_a;
            idx_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          trmt_q    <= 1'b1;
          tx_data_q <= cur_byte_d;
          csum_q    <= csum_q + cur_byte_d;
          state_q   <= GUARD;
        end
        // tx_done may still show the previous byte's completion here.
        GUARD: state_q <= WAIT;
        WAIT: begin
          if (tx_done) begin
            if (idx_q == CSUM_IDX) begin
              done_a_q <= (srv_q == REQ_A);
              done_b_q <= (srv_q == REQ_B);
              state_q  <= DONE;
            end else begin
              if (idx_q != '0) begin
                shreg_q <= shreg_q >> 8;
              end
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= SEND;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign done_a  = done_a_q;
  assign done_b  = done_b_q;
  assign busy    = busy_q;
  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;

endmodule
